pwm_duty_meter: RTL and testbench

Receive-side counterpart of the team's PWM generators. It samples an asynchronous PWM input and measures the period and high time of each cycle. It then computes the duty cycle in whole percent and classifies it against the 25/50/75 % nominal duties. It also flags a stuck-high or stuck-low line. It sits on the consumer side of a PWM link, e.g. a loopback checker for the generator block or a fan/servo feedback input.

---
 rtl/pwm_duty_meter.sv | 147 ++++++++++++++
 tb/tb_pwm_duty_meter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures period, high time and duty class of an asynchronous PWM input
// and flags a line that has stopped toggling.
module pwm_duty_meter #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000,
   parameter int TOL     = 2
) (
   input  logic             CLK_in,
   input  logic             RST,
   input  logic             PWM_in,
   input  logic             EN,
   output logic [CNT_W-1:0] PERIOD,
   output logic [CNT_W-1:0] HIGH_T,
   output logic [6:0]       DUTY_PCT,
   output logic [1:0]       CLASS,
   output logic             MEAS_VALID,
   output logic             OVR,
   output logic             STUCK_HI,
   output logic             STUCK_LO
);
   localparam int DW = CNT_W + 7;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   localparam logic [6:0] LO25 = 7'(25 - TOL), HI25 = 7'(25 + TOL);
   localparam logic [6:0] LO50 = 7'(50 - TOL), HI50 = 7'(50 + TOL);
   localparam logic [6:0] LO75 = 7'(75 - TOL), HI75 = 7'(75 + TOL);

   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

   state_t           st, st_nx;
   logic             s1, sync, prev, rise;
   logic [CNT_W-1:0] per_cnt, hi_cnt;
   logic [CNT_W-1:0] rem, rem_nx;
   logic [6:0]       quo;
   logic [2:0]       it;
   logic             busy, fin;
   logic             act, cap, ovr_c, tmo, stuck;
   logic [DW-1:0]    dvd;
   logic [CNT_W:0]   trial, diff;
   logic             ge;
   logic [1:0]       cls;

   assign rise   = sync & ~prev;
   assign stuck  = STUCK_HI | STUCK_LO;
   assign dvd    = DW'(hi_cnt) * DW'(100);
   // quo holds the unconsumed dividend bits on the left and shifts quotient bits in on the right
   assign trial  = {rem, quo[6]};
   assign diff   = trial - {1'b0, PERIOD};
   assign ge     = trial >= {1'b0, PERIOD};
   assign rem_nx = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
   assign cls    = (quo >= LO25 && quo <= HI25) ? 2'd1 :
                   (quo >= LO50 && quo <= HI50) ? 2'd2 :
                   (quo >= LO75 && quo <= HI75) ? 2'd3 : 2'd0;

   always_ff @(posedge CLK_in or posedge RST)
      if (RST) {s1, sync, prev} <= '0;
      else     {s1, sync, prev} <= {PWM_in, s1, sync};

   always_ff @(posedge CLK_in or posedge RST)
      if (RST) st <= IDLE;
      else     st <= st_nx;

   always_comb
      st_nx = !EN ? IDLE : st == IDLE ? ARM : rise ? RUN : tmo ? ARM : st;

   always_comb begin
      act   = EN && st != IDLE;
      tmo   = act && !rise && !stuck && per_cnt == TMO;
      cap   = EN && st == RUN && rise && !busy;
      ovr_c = EN && st == RUN && rise && busy;
   end

   // after a timeout the counters freeze until the next edge so the flag cannot retrigger
   always_ff @(posedge CLK_in or posedge RST)
      if (RST) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (st == IDLE) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (rise) begin
         per_cnt <= ONE;
         hi_cnt  <= ONE;
      end else if (!stuck) begin
         per_cnt <= per_cnt == '1 ? per_cnt : per_cnt + ONE;
         hi_cnt  <= (sync && hi_cnt != '1) ? hi_cnt + ONE : hi_cnt;
      end

   always_ff @(posedge CLK_in or posedge RST)
      if (RST) begin
         STUCK_HI <= 1'b0;
         STUCK_LO <= 1'b0;
      end else if (act && rise) begin
         STUCK_HI <= 1'b0;
         STUCK_LO <= 1'b0;
      end else if (tmo) begin
         STUCK_HI <= sync;
         STUCK_LO <= ~sync;
      end

   always_ff @(posedge CLK_in or posedge RST)
      if (RST) begin
         rem  <= '0;
         quo  <= '0;
         it   <= '0;
         busy <= 1'b0;
         fin  <= 1'b0;
      end else if (!EN) begin
         busy <= 1'b0;
         fin  <= 1'b0;
      end else if (cap) begin
         rem  <= dvd[DW-1:7];
         quo  <= dvd[6:0];
         it   <= '0;
         busy <= 1'b1;
         fin  <= 1'b0;
      end else if (busy) begin
         rem  <= rem_nx;
         quo  <= {quo[5:0], ge};
         it   <= it + 3'd1;
         busy <= it != 3'd6;
         fin  <= it == 3'd6;
      end else begin
         fin  <= 1'b0;
      end

   always_ff @(posedge CLK_in or posedge RST)
      if (RST) begin
         PERIOD     <= '0;
         HIGH_T     <= '0;
         DUTY_PCT   <= '0;
         CLASS      <= '0;
         MEAS_VALID <= 1'b0;
         OVR        <= 1'b0;
      end else begin
         MEAS_VALID <= EN && fin;
         OVR        <= ovr_c;
         if (cap) begin
            PERIOD <= per_cnt;
            HIGH_T <= hi_cnt;
         end
         if (EN && fin) begin
            DUTY_PCT <= quo;
            CLASS    <= cls;
         end
      end
endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: scoreboard bench driving ideal PWM waveforms and checking each measurement,
// overrun, stuck-line, reset and enable behaviour of pwm_duty_meter.
module tb_pwm_duty_meter;
   localparam int CNT_W = 16, TIMEOUT = 1000, TOL = 2;

   typedef struct {int due; int per; int hi; int duty; int cls;} exp_t;

   logic             CLK_in = 1'b0, RST = 1'b1, PWM_in = 1'b0, EN = 1'b0;
   logic [CNT_W-1:0] PERIOD, HIGH_T;
   logic [6:0]       DUTY_PCT;
   logic [1:0]       CLASS;
   logic             MEAS_VALID, OVR, STUCK_HI, STUCK_LO;

   int   n_cmp = 0, n_bad = 0, cyc = 0, ovr_seen = 0, ovr_exp = 0, last_ld = -100, ph = 0, pl = 0;
   bit   have_prev = 0;
   exp_t q[$];

   pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(TOL)) dut (
      .CLK_in(CLK_in), .RST(RST), .PWM_in(PWM_in), .EN(EN),
      .PERIOD(PERIOD), .HIGH_T(HIGH_T), .DUTY_PCT(DUTY_PCT), .CLASS(CLASS),
      .MEAS_VALID(MEAS_VALID), .OVR(OVR), .STUCK_HI(STUCK_HI), .STUCK_LO(STUCK_LO)
   );

   always #5 CLK_in = ~CLK_in;
   always @(posedge CLK_in) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int cls_of(input int d);
      return (d >= 25 - TOL && d <= 25 + TOL) ? 1 :
             (d >= 50 - TOL && d <= 50 + TOL) ? 2 :
             (d >= 75 - TOL && d <= 75 + TOL) ? 3 : 0;
   endfunction

   task automatic expect_outs(input string tag, input int p, input int h, input int d, input int c);
      check({tag, "_period"}, int'(PERIOD), p);
      check({tag, "_high_t"}, int'(HIGH_T), h);
      check({tag, "_duty"}, int'(DUTY_PCT), d);
      check({tag, "_class"}, int'(CLASS), c);
      check({tag, "_mv"}, int'(MEAS_VALID), 0);
      check({tag, "_ovr"}, int'(OVR), 0);
      check({tag, "_stuck_hi"}, int'(STUCK_HI), 0);
      check({tag, "_stuck_lo"}, int'(STUCK_LO), 0);
   endtask

   // raise the line; the period it closes is expected 11 cycles later unless the divider is busy
   task automatic rise(input bit meas, output int r);
      exp_t e;
      PWM_in = 1'b1;
      r = cyc;
      if (have_prev && meas) begin
         if (r - last_ld < 8) ovr_exp++;
         else begin
            e.due  = r + 11;
            e.per  = ph + pl;
            e.hi   = ph;
            e.duty = ph * 100 / (ph + pl);
            e.cls  = cls_of(e.duty);
            q.push_back(e);
            last_ld = r;
         end
      end
      have_prev = 1;
   endtask

   task automatic pwm(input int h, input int l, input int n);
      int r;
      repeat (n) begin
         rise(1, r);
         ph = h;
         pl = l;
         repeat (h) @(negedge CLK_in);
         PWM_in = 1'b0;
         repeat (l) @(negedge CLK_in);
      end
   endtask

   always @(negedge CLK_in) begin : mon
      exp_t e;
      if (!RST) begin
         if (MEAS_VALID) begin
            if (q.size() == 0) check("unexpected_mv", 1, 0);
            else begin
               e = q.pop_front();
               check("mv_cycle", cyc, e.due);
               check("period", int'(PERIOD), e.per);
               check("high_t", int'(HIGH_T), e.hi);
               check("duty", int'(DUTY_PCT), e.duty);
               check("class", int'(CLASS), e.cls);
            end
         end else if (q.size() != 0 && q[0].due < cyc) begin
            e = q.pop_front();
            check("missing_mv", 0, 1);
         end
         if (OVR) ovr_seen++;
      end
   end

   initial begin
      int r;
      repeat (3) @(negedge CLK_in);
      expect_outs("reset", 0, 0, 0, 0);
      RST = 1'b0;
      EN  = 1'b1;
      repeat (5) @(negedge CLK_in);
      pwm(25, 75, 4);
      pwm(50, 50, 3);
      pwm(75, 25, 2);
      pwm(37, 63, 2);
      pwm(27, 73, 2);
      pwm(3, 3, 8);
      pwm(25, 75, 2);
      // line held high
      rise(1, r);
      while (cyc < r + TIMEOUT + 2) @(negedge CLK_in);
      check("stuck_hi_early", int'(STUCK_HI), 0);
      @(negedge CLK_in);
      check("stuck_hi_set", int'(STUCK_HI), 1);
      check("stuck_hi_lo", int'(STUCK_LO), 0);
      while (cyc < r + 1200) @(negedge CLK_in);
      PWM_in = 1'b0;
      have_prev = 0;
      repeat (20) @(negedge CLK_in);
      check("stuck_hi_hold", int'(STUCK_HI), 1);
      rise(1, r);
      ph = 25;
      pl = 75;
      repeat (2) @(negedge CLK_in);
      check("stuck_hi_pre_clr", int'(STUCK_HI), 1);
      @(negedge CLK_in);
      check("stuck_hi_clr", int'(STUCK_HI), 0);
      repeat (22) @(negedge CLK_in);
      PWM_in = 1'b0;
      repeat (75) @(negedge CLK_in);
      pwm(25, 75, 2);
      // line held low
      rise(1, r);
      ph = 25;
      pl = 75;
      repeat (25) @(negedge CLK_in);
      PWM_in = 1'b0;
      while (cyc < r + TIMEOUT + 2) @(negedge CLK_in);
      check("stuck_lo_early", int'(STUCK_LO), 0);
      @(negedge CLK_in);
      check("stuck_lo_set", int'(STUCK_LO), 1);
      check("stuck_lo_hi", int'(STUCK_HI), 0);
      repeat (200) @(negedge CLK_in);
      have_prev = 0;
      rise(1, r);
      repeat (3) @(negedge CLK_in);
      check("stuck_lo_clr", int'(STUCK_LO), 0);
      repeat (22) @(negedge CLK_in);
      PWM_in = 1'b0;
      repeat (75) @(negedge CLK_in);
      pwm(25, 75, 2);
      // reset during divider iteration 4
      rise(0, r);
      repeat (7) @(negedge CLK_in);
      RST = 1'b1;
      PWM_in = 1'b0;
      @(negedge CLK_in);
      expect_outs("rst_mid", 0, 0, 0, 0);
      repeat (3) @(negedge CLK_in);
      RST = 1'b0;
      have_prev = 0;
      last_ld = -100;
      repeat (5) @(negedge CLK_in);
      pwm(25, 75, 3);
      // enable dropped mid-period
      rise(1, r);
      repeat (25) @(negedge CLK_in);
      PWM_in = 1'b0;
      repeat (15) @(negedge CLK_in);
      EN = 1'b0;
      repeat (30) @(negedge CLK_in);
      expect_outs("en_hold", 100, 25, 25, 1);
      EN = 1'b1;
      repeat (5) @(negedge CLK_in);
      have_prev = 0;
      pwm(37, 63, 3);
      rise(1, r);
      repeat (30) @(negedge CLK_in);
      PWM_in = 1'b0;
      repeat (10) @(negedge CLK_in);
      check("queue_empty", q.size(), 0);
      check("ovr_count", ovr_seen, ovr_exp);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
